// File: rtl/rs_encode_block_pad.sv
// ============================================================================
// Module   : rs_encode_block_pad
// Brief    : Converts a line-count request into an RS block-count request and
//            zero-pads the final partial block to a full block of lines.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rs_encode_block_pad #(
    parameter int NUM_REQ_BLOCKS   = 8,
    parameter int NUM_REQ_BLOCKS_W = 4,
    parameter int DATA_W           = 256,
    parameter int NUM_LINES        = 7,
    parameter int NUM_REQ_LINES_W  = 7
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        src_pad_req_val,
    input  logic [NUM_REQ_LINES_W-1:0]  src_pad_req_num_lines,
    output logic                        pad_src_req_rdy,

    input  logic                        src_pad_req_data_val,
    input  logic [DATA_W-1:0]           src_pad_req_data,
    output logic                        pad_src_req_data_rdy,

    output logic                        pad_encoder_req_val,
    output logic [NUM_REQ_BLOCKS_W-1:0] pad_encoder_req_num_blocks,
    input  logic                        encoder_pad_req_rdy,

    output logic                        pad_encoder_req_data_val,
    output logic [DATA_W-1:0]           pad_encoder_req_data,
    input  logic                        encoder_pad_req_data_rdy,

    output logic                        pad_err_oversize
);

    localparam int LIB_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    localparam logic [NUM_REQ_LINES_W-1:0]  C_LINES    = NUM_REQ_LINES_W'(NUM_LINES);
    localparam logic [NUM_REQ_LINES_W-1:0]  C_ONE_LINE = NUM_REQ_LINES_W'(1);
    localparam logic [NUM_REQ_BLOCKS_W-1:0] C_BLK_LAST = NUM_REQ_BLOCKS_W'(NUM_REQ_BLOCKS - 1);
    localparam logic [NUM_REQ_BLOCKS_W-1:0] C_BLK_ONE  = NUM_REQ_BLOCKS_W'(1);
    localparam logic [LIB_W-1:0]            C_LIB_LAST = LIB_W'(NUM_LINES - 1);
    localparam logic [LIB_W-1:0]            C_LIB_ONE  = LIB_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_REQ   = 3'd2,
        S_DATA  = 3'd3,
        S_PAD   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t                        state_q,      state_d;
    logic [NUM_REQ_LINES_W-1:0]    rem_q,        rem_d;
    logic [NUM_REQ_LINES_W-1:0]    lines_left_q, lines_left_d;
    logic [NUM_REQ_BLOCKS_W-1:0]   blk_q,        blk_d;
    logic [LIB_W-1:0]              lib_q,        lib_d;

    logic w_data_xfer;
    logic w_pad_xfer;
    logic w_drain_xfer;
    logic w_lib_last;
    logic w_last_line;

    assign w_data_xfer  = src_pad_req_data_val & encoder_pad_req_data_rdy;
    assign w_pad_xfer   = encoder_pad_req_data_rdy;
    assign w_drain_xfer = src_pad_req_data_val;
    assign w_lib_last   = (lib_q == C_LIB_LAST);
    assign w_last_line  = (lines_left_q == C_ONE_LINE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            lines_left_q <= '0;
            blk_q        <= '0;
            lib_q        <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            lines_left_q <= lines_left_d;
            blk_q        <= blk_d;
            lib_q        <= lib_d;
        end
    end

    always_comb begin
        state_d                    = state_q;
        rem_d                      = rem_q;
        lines_left_d               = lines_left_q;
        blk_d                      = blk_q;
        lib_d                      = lib_q;

        pad_src_req_rdy            = 1'b0;
        pad_src_req_data_rdy       = 1'b0;
        pad_encoder_req_val        = 1'b0;
        pad_encoder_req_num_blocks = '0;
        pad_encoder_req_data_val   = 1'b0;
        pad_encoder_req_data       = '0;
        pad_err_oversize           = 1'b0;

        case (state_q)
            S_IDLE: begin
                pad_src_req_rdy = 1'b1;
                if (src_pad_req_val) begin
                    rem_d        = src_pad_req_num_lines;
                    lines_left_d = src_pad_req_num_lines;
                    blk_d        = '0;
                    if (src_pad_req_num_lines != '0) begin
                        state_d = S_CALC;
                    end
                end
            end

            // Repeated subtraction stands in for a divider: one block per cycle.
            S_CALC: begin
                if (rem_q > C_LINES) begin
                    if (blk_q == C_BLK_LAST) begin
                        pad_err_oversize = 1'b1;
                        state_d          = S_DRAIN;
                    end else begin
                        rem_d = rem_q - C_LINES;
                        blk_d = blk_q + C_BLK_ONE;
                    end
                end else begin
                    blk_d   = blk_q + C_BLK_ONE;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                pad_encoder_req_val        = 1'b1;
                pad_encoder_req_num_blocks = blk_q;
                if (encoder_pad_req_rdy) begin
                    lib_d   = '0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                pad_encoder_req_data_val = src_pad_req_data_val;
                pad_src_req_data_rdy     = encoder_pad_req_data_rdy;
                pad_encoder_req_data     = src_pad_req_data;
                if (w_data_xfer) begin
                    lines_left_d = lines_left_q - C_ONE_LINE;
                    lib_d        = w_lib_last ? '0 : lib_q + C_LIB_ONE;
                    if (w_last_line) begin
                        state_d = w_lib_last ? S_IDLE : S_PAD;
                    end
                end
            end

            S_PAD: begin
                pad_encoder_req_data_val = 1'b1;
                if (w_pad_xfer) begin
                    if (w_lib_last) begin
                        state_d = S_IDLE;
                    end else begin
                        lib_d = lib_q + C_LIB_ONE;
                    end
                end
            end

            // Oversize request: swallow its data so the source is not left hanging.
            S_DRAIN: begin
                pad_src_req_data_rdy = 1'b1;
                if (w_drain_xfer) begin
                    lines_left_d = lines_left_q - C_ONE_LINE;
                    if (w_last_line) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/rs_encode_block_pad.md
Name: rs_encode_block_pad

Overview:
- Upstream feeder for the streaming RS encode wrapper.
- Accepts a request sized in data lines and converts it to a block count (ceil of lines / NUM_LINES) without a divider.
- Issues the encoder's request, forwards the data lines, and zero-pads the final partial block to a full NUM_LINES lines.
- Drops zero-length and oversize requests so the encoder only ever sees legal block counts.

Parameters:
- NUM_REQ_BLOCKS, 8: maximum blocks per encoder request; must be < 2^NUM_REQ_BLOCKS_W.
- NUM_REQ_BLOCKS_W, 4: width of the block-count field sent to the encoder.
- DATA_W, 256: line width in bits.
- NUM_LINES, 7: lines per RS block; equals ceil(RS_K/(DATA_W/8)).
- NUM_REQ_LINES_W, 7: width of the request line-count field.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- src_pad_req_val  input  1  request valid
- src_pad_req_num_lines  input  NUM_REQ_LINES_W  total data lines in request
- pad_src_req_rdy  output  1  request ready
- src_pad_req_data_val  input  1  data line valid
- src_pad_req_data  input  DATA_W  data line
- pad_src_req_data_rdy  output  1  data line ready
- pad_encoder_req_val  output  1  encoder request valid
- pad_encoder_req_num_blocks  output  NUM_REQ_BLOCKS_W  block count
- encoder_pad_req_rdy  input  1  encoder request ready
- pad_encoder_req_data_val  output  1  encoder data valid
- pad_encoder_req_data  output  DATA_W  encoder data line
- encoder_pad_req_data_rdy  input  1  encoder data ready
- pad_err_oversize  output  1  one-cycle pulse when an oversize request is dropped

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE; all counters clear.
  - pad_src_req_rdy=1, all other outputs 0 (data bus 0).
  - Reset in any state aborts the current request. Beats in flight are discarded; the encoder sees no further beats.
- Handshakes are val/rdy; a transfer occurs on a cycle where both are high.
- Once asserted, outputs hold val and payload stable until rdy.

States:
- IDLE
  - pad_src_req_rdy=1.
  - On accept: rem<=num_lines, lines_left<=num_lines, blk<=0.
  - num_lines==0 → stay IDLE; nothing emitted; request dropped.
  - Otherwise → CALC.
- CALC (one iteration per cycle; all rdy/val outputs low)
  - If rem>NUM_LINES and blk==NUM_REQ_BLOCKS-1 → DRAIN, with pad_err_oversize=1 for that cycle.
  - Else if rem>NUM_LINES: rem-=NUM_LINES, blk+=1.
  - Else: blk+=1 → REQ.
  - Latency: request accepted in cycle T → pad_encoder_req_val first high in cycle T+1+B, where B = block count.
- REQ
  - pad_encoder_req_val=1, num_blocks=blk.
  - On encoder_pad_req_rdy: line_in_blk<=0 → DATA.
  - Source data is not accepted in REQ.
- DATA (combinational pass-through)
  - pad_encoder_req_data_val=src_pad_req_data_val; pad_src_req_data_rdy=encoder_pad_req_data_rdy; data unchanged.
  - On each transfer: lines_left-=1, line_in_blk wraps at NUM_LINES-1.
  - On the transfer of the last line (lines_left==1):
    - line_in_blk==NUM_LINES-1 → IDLE (no pad).
    - Otherwise → PAD.
- PAD
  - pad_encoder_req_data_val=1, data=0, pad_src_req_data_rdy=0.
  - On each transfer line_in_blk+=1.
  - The transfer with line_in_blk==NUM_LINES-1 → IDLE.
  - Number of pad lines = (NUM_LINES - num_lines mod NUM_LINES) mod NUM_LINES.
- DRAIN
  - pad_src_req_data_rdy=1; no encoder traffic.
  - Each accepted line: lines_left-=1; last line → IDLE.
- Arithmetic widths:
  - rem and lines_left are NUM_REQ_LINES_W bits.
  - blk and line_in_blk are sized for their maxima with no overflow; blk is compared before increment.
- Block boundaries:
  - Total encoder data lines per request is always blk*NUM_LINES.
  - Exact multiples produce no PAD state.
- Back-to-back requests:
  - A new request is accepted only in IDLE.
  - The first IDLE cycle after the final PAD, DATA or DRAIN beat can accept.

Test Plan (NUM_LINES=7, NUM_REQ_BLOCKS=8, NUM_REQ_BLOCKS_W=4, NUM_REQ_LINES_W=7, DATA_W=256):
1. num_lines=14, lines 0..13 carry index values, encoder always ready → num_blocks=2 issued 3 cycles after accept; 14 lines forwarded in order, unchanged; no zero lines; IDLE afterwards.
2. num_lines=9 → num_blocks=2; 9 source lines, then 5 all-zero lines; source rdy low during the pad lines.
3. num_lines=1, then immediately num_lines=7 → first: num_blocks=1, 1 data + 6 zero lines; second: num_blocks=1, 7 lines, no pad; second request accepted on the first IDLE cycle.
4. num_lines=0, then num_lines=3 → no encoder request for the first; second yields num_blocks=1 with 3 data + 4 zero lines.
5. num_lines=57 → pad_err_oversize pulses exactly once; 57 lines consumed with rdy=1; zero encoder val cycles. A following num_lines=56 yields num_blocks=8 and 56 lines.
6. Backpressure and reset:
   - encoder_pad_req_rdy held low 5 cycles → req_val and num_blocks held stable.
   - encoder data rdy random 50% on num_lines=10 → 10 data + 4 zero lines, no loss or duplication.
   - rst asserted after 2 data beats → next cycle all outputs at reset values; a new request is processed correctly.
